// File: rtl/reaction_det.sv
// rtl/reaction_det.sv - reaction-test receiver: target latch, key debounce, ms reaction timer
module reaction_det #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int DEB_MS     = 10,
  parameter int TIMEOUT_MS = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        det_start,
  input  logic [7:0]  led,
  input  logic [7:0]  key_n,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic        miss,
  output logic        timeout,
  output logic [13:0] react_ms
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int DIV_W    = $clog2(TICK_DIV + 1);
  localparam int DEB_W    = $clog2(DEB_MS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_MS - 1);
  localparam logic [13:0]      TO_MS    = 14'(TIMEOUT_MS);

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  state_t           state, state_nx;
  logic [7:0]       key_s1, key_s2, key_smp, key_db, key_db_d, new_press, pressed;
  logic [7:0]       target, target_nx;
  logic [13:0]      react_nx;
  logic             hit_nx, miss_nx, to_nx, done_nx;
  logic [DIV_W-1:0] div_cnt;
  logic [DEB_W-1:0] deb_cnt;
  logic             ms_tick, deb_tick;

  assign pressed   = ~key_s2;
  assign ms_tick   = (div_cnt == DIV_LAST);
  assign deb_tick  = ms_tick && (deb_cnt == DEB_LAST);
  assign new_press = key_db & ~key_db_d;
  assign busy      = (state == MEASURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= 8'hFF;
      key_s2 <= 8'hFF;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
    end
  end

  // The ms phase is realigned on det_start so the first tick lands one full ms into the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      deb_cnt <= '0;
    end else begin
      if (det_start || ms_tick) div_cnt <= '0;
      else                      div_cnt <= div_cnt + 1'b1;
      if (ms_tick) deb_cnt <= deb_tick ? '0 : deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_smp  <= '0;
      key_db   <= '0;
      key_db_d <= '0;
    end else begin
      key_db_d <= key_db;
      if (deb_tick) begin
        key_smp <= pressed;
        if (pressed == key_smp) key_db <= key_smp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      target   <= '0;
      react_ms <= '0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      timeout  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      target   <= target_nx;
      react_ms <= react_nx;
      hit      <= hit_nx;
      miss     <= miss_nx;
      timeout  <= to_nx;
      done     <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    target_nx = target;
    react_nx  = react_ms;
    hit_nx    = hit;
    miss_nx   = miss;
    to_nx     = timeout;
    done_nx   = 1'b0;
    if (det_start) begin
      target_nx = led;
      react_nx  = '0;
      hit_nx    = 1'b0;
      miss_nx   = 1'b0;
      to_nx     = 1'b0;
      state_nx  = (led != 8'h00) ? MEASURE : IDLE;
    end else if (state == MEASURE) begin
      if (new_press != 8'h00) begin
        // Whole debounced set is compared, so simultaneous extra keys count as a miss.
        hit_nx   = (key_db == target);
        miss_nx  = (key_db != target);
        done_nx  = 1'b1;
        state_nx = DONE;
        if (ms_tick && react_ms != TO_MS) react_nx = react_ms + 14'd1;
      end else if (ms_tick) begin
        if (react_ms == TO_MS) begin
          to_nx    = 1'b1;
          done_nx  = 1'b1;
          state_nx = DONE;
        end else begin
          react_nx = react_ms + 14'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reaction_det.sv
// tb/tb_reaction_det.sv - self-checking bench for reaction_det (12 cycles per ms, 50 ms window)
module tb_reaction_det;

  localparam int CPM = 12;
  localparam int TO  = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        det_start = 1'b0;
  logic [7:0]  led = 8'h00;
  logic [7:0]  key_n = 8'hFF;
  logic        busy, done, hit, miss, timeout;
  logic [13:0] react_ms;

  reaction_det #(.CLK_HZ(12_000), .DEB_MS(1), .TIMEOUT_MS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .det_start(det_start), .led(led), .key_n(key_n),
    .busy(busy), .done(done), .hit(hit), .miss(miss), .timeout(timeout), .react_ms(react_ms)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] led;
    logic [7:0] keys;
    int         press_ms;
    int         e_hit, e_miss, e_to, e_lo, e_hi;
  } vec_t;

  typedef struct {
    int ok, r_hit, r_miss, r_to, react, dones, busy_after;
  } res_t;

  int n_total = 0;
  int n_pass  = 0;
  int done_cnt = 0;

  always @(posedge clk) if (done) done_cnt = done_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ms(input int n);
    cyc(n * CPM);
  endtask

  task automatic start(input logic [7:0] l);
    det_start = 1'b1;
    led = l;
    cyc(1);
    det_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic run_round(input logic [7:0] l, input logic [7:0] keys, input int press_ms,
                           output res_t r);
    int d0;
    d0 = done_cnt;
    start(l);
    if (press_ms >= 0) begin
      wait_ms(press_ms);
      key_n = ~keys;
    end
    wait_done(65 * CPM, r.ok);
    r.r_hit  = int'(hit);
    r.r_miss = int'(miss);
    r.r_to   = int'(timeout);
    r.react  = int'(react_ms);
    cyc(2);
    r.busy_after = int'(busy);
    wait_ms(3);
    r.dones = done_cnt - d0;
    key_n = 8'hFF;
    wait_ms(4);
  endtask

  // Outcome from the game rules: no press -> timeout at the window limit; exact set -> hit.
  function automatic vec_t ref_model(input logic [7:0] l, input logic [7:0] keys, input int press_ms);
    vec_t e;
    e.led = l; e.keys = keys; e.press_ms = press_ms;
    if (press_ms < 0) begin
      e.e_hit = 0; e.e_miss = 0; e.e_to = 1; e.e_lo = TO; e.e_hi = TO;
    end else begin
      e.e_hit  = (keys == l) ? 1 : 0;
      e.e_miss = 1 - e.e_hit;
      e.e_to   = 0;
      e.e_lo   = press_ms;
      e.e_hi   = press_ms + 2;
    end
    return e;
  endfunction

  vec_t vecs[6];
  res_t r;
  vec_t e;
  int   ok, d0, saved_react, mode, k;
  logic [7:0] tl, tk, other;

  initial begin
    vecs[0] = '{8'h04, 8'h04, 20, 1, 0, 0, 20, 22};
    vecs[1] = '{8'h04, 8'h20, 10, 0, 1, 0, 10, 12};
    vecs[2] = '{8'h01, 8'h00, -1, 0, 0, 1, 50, 50};
    vecs[3] = '{8'h80, 8'h80,  0, 1, 0, 0,  0,  2};
    vecs[4] = '{8'h10, 8'h18,  7, 0, 1, 0,  7,  9};
    vecs[5] = '{8'h40, 8'h40, 45, 1, 0, 0, 45, 47};

    cyc(3);
    check("reset_outs", int'({busy, done, hit, miss, timeout, react_ms}), 0);
    rst_n = 1'b1;
    wait_ms(3);

    // Async reset in the middle of an open window
    start(8'h04);
    wait_ms(5);
    check("pre_rst_busy", int'(busy), 1);
    check_range("pre_rst_react", int'(react_ms), 4, 6);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_react", int'(react_ms), 0);
    check("async_rst_res", int'({hit, miss, timeout}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ms(3);

    for (int i = 0; i < 6; i++) begin
      run_round(vecs[i].led, vecs[i].keys, vecs[i].press_ms, r);
      check($sformatf("v%0d_done_seen", i), r.ok, 1);
      check($sformatf("v%0d_hit", i), r.r_hit, vecs[i].e_hit);
      check($sformatf("v%0d_miss", i), r.r_miss, vecs[i].e_miss);
      check($sformatf("v%0d_timeout", i), r.r_to, vecs[i].e_to);
      check_range($sformatf("v%0d_react", i), r.react, vecs[i].e_lo, vecs[i].e_hi);
      check($sformatf("v%0d_done_count", i), r.dones, 1);
      check($sformatf("v%0d_busy_after", i), r.busy_after, 0);
    end

    // Wrong key, then the right key while in DONE: result must not move
    d0 = done_cnt;
    start(8'h04);
    wait_ms(10);
    key_n = ~8'h20;
    wait_done(20 * CPM, ok);
    check("wrong_done_seen", ok, 1);
    check("wrong_miss", int'(miss), 1);
    check("wrong_hit", int'(hit), 0);
    saved_react = int'(react_ms);
    key_n = 8'hFF;
    wait_ms(4);
    key_n = ~8'h04;
    wait_ms(5);
    check("late_press_hit", int'(hit), 0);
    check("late_press_miss", int'(miss), 1);
    check("late_press_react", int'(react_ms), saved_react);
    check("late_press_dones", done_cnt - d0, 1);
    key_n = 8'hFF;
    wait_ms(4);

    // Key held across det_start only counts once re-pressed
    key_n = ~8'h01;
    wait_ms(4);
    d0 = done_cnt;
    start(8'h01);
    wait_ms(10);
    key_n = 8'hFF;
    wait_ms(19);
    check("held_no_done", done_cnt - d0, 0);
    check("held_still_busy", int'(busy), 1);
    wait_ms(1);
    key_n = ~8'h01;
    wait_done(10 * CPM, ok);
    check("held_done_seen", ok, 1);
    check("held_hit", int'(hit), 1);
    check_range("held_react", int'(react_ms), 30, 32);
    key_n = 8'hFF;
    wait_ms(4);

    // Bouncing contact produces a single result
    d0 = done_cnt;
    start(8'h08);
    wait_ms(5);
    for (int j = 0; j < 2; j++) begin
      key_n[3] = 1'b0; cyc(2);
      key_n[3] = 1'b1; cyc(2);
    end
    key_n[3] = 1'b0;
    wait_done(10 * CPM, ok);
    check("bounce_done_seen", ok, 1);
    check("bounce_hit", int'(hit), 1);
    wait_ms(5);
    check("bounce_dones", done_cnt - d0, 1);
    key_n = 8'hFF;
    wait_ms(4);

    // Empty target never opens a window
    d0 = done_cnt;
    start(8'h00);
    cyc(1);
    check("empty_busy", int'(busy), 0);
    key_n = ~8'h02;
    wait_ms(4);
    check("empty_dones", done_cnt - d0, 0);
    check("empty_res", int'({hit, miss, timeout}), 0);
    key_n = 8'hFF;
    wait_ms(4);

    // Second det_start mid-window restarts timing and target
    d0 = done_cnt;
    start(8'h01);
    wait_ms(10);
    start(8'h02);
    wait_ms(5);
    key_n = ~8'h02;
    wait_done(10 * CPM, ok);
    check("restart_done_seen", ok, 1);
    check("restart_hit", int'(hit), 1);
    check_range("restart_react", int'(react_ms), 5, 7);
    wait_ms(3);
    check("restart_dones", done_cnt - d0, 1);
    key_n = 8'hFF;
    wait_ms(4);

    // Randomized rounds against the rule-level model
    for (int i = 0; i < 20; i++) begin
      tl = 8'(1 << $urandom_range(7));
      k = $urandom_range(7);
      while (8'(1 << k) == tl) k = $urandom_range(7);
      other = 8'(1 << k);
      mode = $urandom_range(3);
      tk = (mode == 0) ? tl : (mode == 1) ? other : (mode == 2) ? (tl | other) : 8'h00;
      e = ref_model(tl, tk, (mode == 3) ? -1 : $urandom_range(0, 40));
      run_round(e.led, e.keys, e.press_ms, r);
      check($sformatf("rnd%0d_outcome", i), r.r_hit + 2 * r.r_miss + 4 * r.r_to,
            e.e_hit + 2 * e.e_miss + 4 * e.e_to);
      check_range($sformatf("rnd%0d_react", i), r.react, e.e_lo, e.e_hi);
      check($sformatf("rnd%0d_dones", i), r.dones, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
